// File: rtl/program_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   ld_state_t : loader FSM states (length header, data words, terminal states)
//   rx_state_t : UART receiver FSM states
//   HDR_BYTES  : number of bytes in the little-endian length header
package program_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERROR
  } ld_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BITS,
    STOP
  } rx_state_t;

  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a 2-FF input synchroniser.
// A synchronised falling edge starts a frame; the start bit is re-checked at
// mid-bit so short glitches are rejected, then each data bit and the stop bit
// are sampled one bit period apart.
// Ports:
//   sysclk      : system clock
//   rst         : asynchronous active-low reset
//   rx          : serial line, idle high, asynchronous to sysclk
//   byte_valid  : one-cycle pulse, byte_data holds the received byte
//   byte_data   : last received byte (stable until the next frame shifts in)
//   framing_err : one-cycle pulse when the stop bit is sampled low
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err
);
  import program_loader_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t      state, state_nxt;
  logic [1:0]     sync;
  logic           rx_s;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           tick_half, tick_full;

  assign rx_s      = sync[1];
  assign tick_half = (cnt == HALF_M1);
  assign tick_full = (cnt == FULL_M1);
  assign byte_data = shreg;

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b11;
      state <= IDLE;
    end else begin
      sync  <= {sync[0], rx};
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      // A line that is high again at mid start bit was only a glitch.
      START:   if (tick_half) state_nxt = rx_s ? IDLE : BITS;
      BITS:    if (tick_full && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (tick_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt restarts at every sample point so the next sample lands one bit later
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        START: cnt <= tick_half ? '0 : cnt + 1'b1;
        BITS: begin
          if (tick_full) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_full) begin
            cnt <= '0;
            if (rx_s) byte_valid  <= 1'b1;
            else      framing_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// UART boot loader feeding the CPU program-memory write port.
// Receives a 16-bit little-endian word count followed by that many 32-bit
// little-endian instruction words and writes each word to program memory.
// The CPU is held in reset until the whole image has been written.
// Ports:
//   sysclk   : system clock
//   rst      : asynchronous active-low reset
//   uart_rx  : serial input, 8N1
//   wr_en    : one-cycle program-memory write strobe
//   wr_addr  : word-aligned byte address of the written word
//   wr_data  : instruction word
//   cpu_hold : high while the image is not (yet) loaded
//   done     : image fully written (sticky)
//   err      : framing or length error (sticky until rst)
module program_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PC_WIDTH     = 12
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                uart_rx,
  output logic                wr_en,
  output logic [PC_WIDTH-1:0] wr_addr,
  output logic [31:0]         wr_data,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);
  import program_loader_pkg::*;

  localparam int IW        = PC_WIDTH - 2;
  localparam int LW        = HDR_BYTES * 8;
  localparam int CAP_WORDS = 2 ** IW;

  ld_state_t      state, state_nxt;
  logic           byte_valid, framing_err;
  logic [7:0]     byte_data;
  logic [LW-1:0]  count;
  logic [LW-1:0]  hdr_len;
  logic [23:0]    word;
  logic [1:0]     bcnt;
  logic [IW-1:0]  idx;
  logic           last_word;
  logic           fin_pend;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .sysclk      (sysclk),
    .rst         (rst),
    .rx          (uart_rx),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .framing_err (framing_err)
  );

  assign hdr_len   = {byte_data, count[7:0]};
  assign last_word = ((32'(idx) + 32'd1) == 32'(count));

  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERROR);

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) state <= LEN_LO;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LEN_LO: begin
        if (framing_err)     state_nxt = ERROR;
        else if (byte_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        if (framing_err) begin
          state_nxt = ERROR;
        end else if (byte_valid) begin
          if (hdr_len == '0)                state_nxt = DONE;
          else if (int'(hdr_len) > CAP_WORDS) state_nxt = ERROR;
          else                              state_nxt = DATA;
        end
      end
      // DONE waits one cycle behind the final write strobe (fin_pend).
      DATA: begin
        if (framing_err)   state_nxt = ERROR;
        else if (fin_pend) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = LEN_LO;
    endcase
  end

  // Bytes enter at the top of a 24-bit shifter; the 4th byte completes the
  // word directly into wr_data, so an incomplete word never reaches memory.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      count    <= '0;
      word     <= '0;
      bcnt     <= '0;
      idx      <= '0;
      fin_pend <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      fin_pend <= 1'b0;
      if (byte_valid) begin
        case (state)
          LEN_LO: count[7:0]  <= byte_data;
          LEN_HI: count[15:8] <= byte_data;
          DATA: begin
            bcnt <= bcnt + 1'b1;
            if (bcnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_data  <= {byte_data, word};
              wr_addr  <= {idx, 2'b00};
              idx      <= idx + 1'b1;
              fin_pend <= last_word;
            end else begin
              word <= {byte_data, word[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int CPB = 16;
  localparam int PCW = 12;

  logic           sysclk = 1'b0;
  logic           rst = 1'b0;
  logic           uart_rx = 1'b1;
  logic           wr_en;
  logic [PCW-1:0] wr_addr;
  logic [31:0]    wr_data;
  logic           cpu_hold, done, err;

  always #5 sysclk = ~sysclk;

  program_loader #(.CLKS_PER_BIT(CPB), .PC_WIDTH(PCW)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  int total = 0;
  int bad = 0;
  longint cyc = 0;

  // observed writes since the last reset
  logic [PCW-1:0] got_addr[$];
  logic [31:0]    got_data[$];
  longint         got_cyc[$];
  longint         done_cyc;
  logic           done_q;

  // frames to send: byte, bad-stop flag, idle gap after the frame
  logic [7:0]     tx_b[$];
  bit             tx_bad[$];
  int             tx_gap[$];

  // reference results
  logic [PCW-1:0] exp_addr[$];
  logic [31:0]    exp_data[$];
  bit             exp_done, exp_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (!rst) begin
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      done_cyc <= -1;
      done_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
        got_cyc.push_back(cyc);
      end
      done_q <= done;
      if (done && !done_q) done_cyc <= cyc;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_tx();
    tx_b.delete();
    tx_bad.delete();
    tx_gap.delete();
  endtask

  task automatic add(input logic [7:0] b, input bit is_bad, input int gap);
    tx_b.push_back(b);
    tx_bad.push_back(is_bad);
    tx_gap.push_back(gap);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    uart_rx = good;
    repeat (CPB) @(negedge sysclk);
    uart_rx = 1'b1;
  endtask

  task automatic apply_reset(input string name);
    @(negedge sysclk);
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge sysclk);
    check_eq({name, ".rst_wr_en"}, wr_en, 0);
    check_eq({name, ".rst_wr_addr"}, wr_addr, 0);
    check_eq({name, ".rst_wr_data"}, wr_data, 0);
    check_eq({name, ".rst_cpu_hold"}, cpu_hold, 1);
    check_eq({name, ".rst_done"}, done, 0);
    check_eq({name, ".rst_err"}, err, 0);
    rst = 1'b1;
    repeat (4) @(negedge sysclk);
  endtask

  // Image-level reference: walk the byte stream, interpret the header,
  // group data bytes into little-endian words, stop at the first bad frame
  // or once the image is complete.
  task automatic model();
    int len;
    int k;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err = 0;
    len = 0;
    for (int i = 0; i < tx_b.size(); i++) begin
      if (exp_done || exp_err) break;
      if (tx_bad[i]) begin
        exp_err = 1;
        break;
      end
      if (i == 0) begin
        len = int'(tx_b[0]);
      end else if (i == 1) begin
        len = len + 256 * int'(tx_b[1]);
        if (len == 0) exp_done = 1;
        else if (len > 2 ** (PCW - 2)) exp_err = 1;
      end else begin
        k = (i - 2) / 4;
        if ((i - 2) % 4 == 3) begin
          exp_addr.push_back(PCW'(4 * k));
          exp_data.push_back({tx_b[i], tx_b[i-1], tx_b[i-2], tx_b[i-3]});
          if (k == len - 1) exp_done = 1;
        end
      end
    end
  endtask

  task automatic send_all(input int first, input int last);
    for (int i = first; i < last; i++) begin
      send_frame(tx_b[i], !tx_bad[i]);
      repeat (tx_gap[i]) @(negedge sysclk);
    end
  endtask

  task automatic run_and_check(input string name, input bit glitch);
    int n;
    apply_reset(name);
    if (glitch) begin
      uart_rx = 1'b0;
      repeat (4) @(negedge sysclk);
      uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge sysclk);
    end
    send_all(0, tx_b.size());
    repeat (2 * CPB) @(negedge sysclk);
    model();
    check_eq({name, ".nwr"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s.addr%0d", name, i), got_addr[i], exp_addr[i]);
      check_eq($sformatf("%s.data%0d", name, i), got_data[i], exp_data[i]);
      if (i > 0)
        check_eq($sformatf("%s.gap%0d", name, i), got_cyc[i] - got_cyc[i-1] >= 40 * CPB, 1);
    end
    check_eq({name, ".done"}, done, exp_done);
    check_eq({name, ".err"}, err, exp_err);
    check_eq({name, ".cpu_hold"}, cpu_hold, !exp_done);
    if (exp_done && n > 0 && n == exp_addr.size())
      check_eq({name, ".done_lat"}, done_cyc, got_cyc[n-1] + 1);
  endtask

  initial begin
    int len, mode, pos, extra;
    logic [7:0] img[8];
    img = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};

    // two-word image
    clear_tx();
    add(8'h02, 0, 0); add(8'h00, 0, 0);
    for (int i = 0; i < 8; i++) add(img[i], 0, 0);
    run_and_check("two_words", 0);
    check_eq("two_words.w0", got_data.size() > 0 ? got_data[0] : 32'h0, 32'h00500513);
    check_eq("two_words.w1", got_data.size() > 1 ? got_data[1] : 32'h0, 32'h00A00593);

    // empty image
    clear_tx();
    add(8'h00, 0, 0); add(8'h00, 0, 0);
    run_and_check("empty", 0);

    // count 1025 exceeds capacity, following bytes ignored
    clear_tx();
    add(8'h01, 0, 0); add(8'h04, 0, 0);
    for (int i = 0; i < 4; i++) add(img[i], 0, 0);
    run_and_check("too_long", 0);

    // framing error after two data bytes
    clear_tx();
    add(8'h01, 0, 0); add(8'h00, 0, 0);
    add(8'h13, 0, 0); add(8'h05, 0, 0);
    add(8'h50, 1, 2 * CPB);
    run_and_check("frame_err", 0);

    // glitch before a one-word image
    clear_tx();
    add(8'h01, 0, 0); add(8'h00, 0, 0);
    for (int i = 0; i < 4; i++) add(img[i], 0, 0);
    run_and_check("glitch", 1);

    // reset after 6 of 8 data bytes, then a full resend
    clear_tx();
    add(8'h02, 0, 0); add(8'h00, 0, 0);
    for (int i = 0; i < 8; i++) add(img[i], 0, 0);
    apply_reset("mid_pre");
    send_all(0, 8);
    repeat (4) @(negedge sysclk);
    check_eq("mid_pre.nwr", got_addr.size(), 1);
    check_eq("mid_pre.w0", got_data.size() > 0 ? got_data[0] : 32'h0, 32'h00500513);
    check_eq("mid_pre.done", done, 0);
    run_and_check("mid_rst", 0);

    // random images, some with bad frames, oversize counts or trailing bytes
    for (int t = 0; t < 6; t++) begin
      clear_tx();
      mode = $urandom_range(0, 2);
      len = (mode == 2) ? $urandom_range(1025, 65535) : $urandom_range(1, 3);
      add(8'(len), 0, $urandom_range(0, 2) * CPB);
      add(8'(len >> 8), 0, 0);
      extra = $urandom_range(0, 2);
      for (int i = 0; i < 4 * ((mode == 2) ? 1 : len) + extra; i++)
        add(8'($urandom), 0, $urandom_range(0, 1) * $urandom_range(1, 3 * CPB));
      if (mode == 1) begin
        pos = $urandom_range(0, tx_b.size() - 1);
        tx_bad[pos] = 1;
        tx_gap[pos] = 2 * CPB;
      end
      run_and_check($sformatf("rnd%0d_m%0d", t, mode), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
